// File: rtl/sfif_rx_ctrl.sv
// sfif_rx_ctrl: SFIF receive-side controller. Parses 64-bit RX TLP beats,
// forwards them to the capture FIFO, checks framing and length, returns
// posted/non-posted credits and counts TLPs against a programmed target.
module sfif_rx_ctrl (
   input  logic        clk_125,
   input  logic        rstn,
   input  logic        enable,
   input  logic        run,
   input  logic [15:0] rx_cycles,
   input  logic        loop,
   input  logic        rx_st,
   input  logic        rx_end,
   input  logic [63:0] rx_data,
   input  logic        rx_fifo_full,
   output logic        rx_fifo_wr,
   output logic [65:0] rx_fifo_data,
   output logic        ph_cr,
   output logic        pd_cr,
   output logic        nph_cr,
   output logic [8:0]  pd_num,
   output logic [15:0] tlp_cnt,
   output logic        err_frame,
   output logic        err_len,
   output logic        err_ovf,
   output logic        done,
   output logic [2:0]  sm
);

   localparam int unsigned DW = 64;
   localparam int unsigned CW = 16;
   localparam int unsigned LW = 10;
   localparam int unsigned BW = 11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_HDR    = 3'b001,
      S_DATA   = 3'b010,
      S_CREDIT = 3'b011,
      S_DONE   = 3'b110
   } state_e;

   // Data DW carried by a header (0 for no-data formats, len 0 means 1024).
   function automatic logic [BW-1:0] data_dw(input logic [1:0] fmt, input logic [LW-1:0] len);
      if (!fmt[1])        return '0;
      else if (len == '0) return BW'(1024);
      else                return BW'(len);
   endfunction

   // Expected beat count: ceil((hdr_dw + data_dw) / 2).
   function automatic logic [LW-1:0] calc_exp(input logic [1:0] fmt, input logic [LW-1:0] len);
      logic [BW-1:0] tot;
      tot = data_dw(fmt, len) + (fmt[0] ? BW'(4) : BW'(3)) + BW'(1);
      return tot[BW-1:1];
   endfunction

   // Posted data credits: ceil(data_dw / 4).
   function automatic logic [8:0] calc_pd(input logic [1:0] fmt, input logic [LW-1:0] len);
      logic [BW-1:0] tot;
      tot = data_dw(fmt, len) + BW'(3);
      return tot[BW-1:2];
   endfunction

   state_e          state_q, state_d;
   logic            run_q;
   logic [1:0]      fmt_q, fmt_d;
   logic [4:0]      type_q, type_d;
   logic [LW-1:0]   len_q, len_d;
   logic [BW-1:0]   beat_q, beat_d;

   logic            wr_q, wr_d;
   logic [DW+1:0]   data_q, data_d;
   logic            ph_q, ph_d, pd_q, pd_d, nph_q, nph_d;
   logic [8:0]      pd_num_q, pd_num_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ef_q, ef_d, el_q, el_d, eo_q, eo_d;
   logic            done_q, done_d;

   logic            run_rise_c, hit_c, hdr_mode_c, beat_acc_c, end_acc_c;
   logic            frame_err_c, cnt_inc_c, posted_c, np_c, cpl_c, len_bad_c;
   logic [CW-1:0]   cnt_next_c;

   assign run_rise_c = run & ~run_q;
   assign cnt_next_c = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
   assign hit_c      = ~loop & (rx_cycles != '0) & (cnt_next_c == rx_cycles);

   // State register and header/beat tracking.
   always_ff @(posedge clk_125 or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         run_q   <= 1'b0;
         fmt_q   <= '0;
         type_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run;
         fmt_q   <= fmt_d;
         type_q  <= type_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
      end
   end

   // Next state, header capture and beat acceptance.
   always_comb begin
      state_d     = state_q;
      fmt_d       = fmt_q;
      type_d      = type_q;
      len_d       = len_q;
      beat_d      = beat_q;
      hdr_mode_c  = 1'b0;
      beat_acc_c  = 1'b0;
      frame_err_c = 1'b0;
      cnt_inc_c   = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (run) state_d = S_HDR;
            S_HDR:    hdr_mode_c = 1'b1;
            S_DATA: begin
               beat_acc_c  = 1'b1;
               frame_err_c = rx_st;
               if (rx_end) state_d = S_CREDIT;
            end
            S_CREDIT: begin
               cnt_inc_c = 1'b1;
               if (hit_c) state_d = S_DONE;
               else       hdr_mode_c = 1'b1;
            end
            S_DONE:   if (run_rise_c) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
      // CREDIT handles a back-to-back start exactly like HDR.
      if (hdr_mode_c) begin
         state_d = S_HDR;
         if (rx_st) begin
            beat_acc_c = 1'b1;
            state_d    = rx_end ? S_CREDIT : S_DATA;
         end else if (rx_end) begin
            frame_err_c = 1'b1;
         end
      end
      if (beat_acc_c) begin
         if (rx_st) begin
            fmt_d  = rx_data[62:61];
            type_d = rx_data[60:56];
            len_d  = rx_data[41:32];
            beat_d = BW'(1);
         end else if (beat_q != '1) begin
            beat_d = beat_q + BW'(1);
         end
      end
   end

   assign end_acc_c = beat_acc_c & rx_end;
   assign len_bad_c = beat_d != BW'(calc_exp(fmt_d, len_d));
   assign cpl_c     = (type_d == 5'b01010) | (type_d == 5'b01011);
   assign posted_c  = fmt_d[1] & (type_d[4:3] == 2'b00);
   assign np_c      = ~fmt_d[1] & ~cpl_c;

   // Next values for FIFO port, credit pulses, counter and sticky errors.
   always_comb begin
      wr_d     = beat_acc_c & ~rx_fifo_full;
      data_d   = wr_d ? {rx_st, rx_end, rx_data} : data_q;
      ph_d     = end_acc_c & posted_c;
      pd_d     = end_acc_c & posted_c;
      nph_d    = end_acc_c & np_c;
      pd_num_d = (end_acc_c & posted_c) ? calc_pd(fmt_d, len_d) : 9'd0;
      cnt_d    = cnt_inc_c ? cnt_next_c : cnt_q;
      ef_d     = ef_q | frame_err_c;
      el_d     = el_q | (end_acc_c & len_bad_c);
      eo_d     = eo_q | (beat_acc_c & rx_fifo_full);
      if (run_rise_c) begin
         cnt_d = '0;
         ef_d  = 1'b0;
         el_d  = 1'b0;
         eo_d  = 1'b0;
      end
      done_d   = state_d == S_DONE;
   end

   // Output registers.
   always_ff @(posedge clk_125 or negedge rstn) begin
      if (!rstn) begin
         wr_q     <= 1'b0;
         data_q   <= '0;
         ph_q     <= 1'b0;
         pd_q     <= 1'b0;
         nph_q    <= 1'b0;
         pd_num_q <= '0;
         cnt_q    <= '0;
         ef_q     <= 1'b0;
         el_q     <= 1'b0;
         eo_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         data_q   <= data_d;
         ph_q     <= ph_d;
         pd_q     <= pd_d;
         nph_q    <= nph_d;
         pd_num_q <= pd_num_d;
         cnt_q    <= cnt_d;
         ef_q     <= ef_d;
         el_q     <= el_d;
         eo_q     <= eo_d;
         done_q   <= done_d;
      end
   end

   assign rx_fifo_wr   = wr_q;
   assign rx_fifo_data = data_q;
   assign ph_cr        = ph_q;
   assign pd_cr        = pd_q;
   assign nph_cr       = nph_q;
   assign pd_num       = pd_num_q;
   assign tlp_cnt      = cnt_q;
   assign err_frame    = ef_q;
   assign err_len      = el_q;
   assign err_ovf      = eo_q;
   assign done         = done_q;
   assign sm           = 3'(state_q);

endmodule

// File: tb/tb_sfif_rx_ctrl.sv
// tb_sfif_rx_ctrl: scoreboard bench for sfif_rx_ctrl with a TLP-level model.
module tb_sfif_rx_ctrl;

   logic        clk_125 = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0, run = 1'b0, loop = 1'b0;
   logic [15:0] rx_cycles = '0;
   logic        rx_st = 1'b0, rx_end = 1'b0, rx_fifo_full = 1'b0;
   logic [63:0] rx_data = '0;
   logic        rx_fifo_wr, ph_cr, pd_cr, nph_cr;
   logic [65:0] rx_fifo_data;
   logic [8:0]  pd_num;
   logic [15:0] tlp_cnt;
   logic        err_frame, err_len, err_ovf, done;
   logic [2:0]  sm;

   int n_cmp = 0;
   int n_bad = 0;

   logic [65:0] exp_wr_q[$];
   logic [11:0] exp_cr_q[$];
   int m_cnt = 0;
   bit m_ef = 0, m_el = 0, m_eo = 0;

   always #4 clk_125 = ~clk_125;

   sfif_rx_ctrl dut (
      .clk_125(clk_125), .rstn(rstn), .enable(enable), .run(run),
      .rx_cycles(rx_cycles), .loop(loop), .rx_st(rx_st), .rx_end(rx_end),
      .rx_data(rx_data), .rx_fifo_full(rx_fifo_full), .rx_fifo_wr(rx_fifo_wr),
      .rx_fifo_data(rx_fifo_data), .ph_cr(ph_cr), .pd_cr(pd_cr), .nph_cr(nph_cr),
      .pd_num(pd_num), .tlp_cnt(tlp_cnt), .err_frame(err_frame), .err_len(err_len),
      .err_ovf(err_ovf), .done(done), .sm(sm)
   );

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // TLP size from the header: header DW plus data DW, two DW per beat.
   function automatic int exp_beats(input logic [1:0] fmt, input logic [9:0] len);
      int hdr, dd;
      hdr = fmt[0] ? 4 : 3;
      dd  = fmt[1] ? ((len == 0) ? 1024 : int'(len)) : 0;
      return (hdr + dd + 1) / 2;
   endfunction

   // Credit return as {ph, pd, nph, pd_num}; zero means no pulse expected.
   function automatic logic [11:0] exp_credit(input logic [1:0] fmt, input logic [4:0] typ,
                                              input logic [9:0] len);
      int dd;
      logic [8:0] pn;
      dd = fmt[1] ? ((len == 0) ? 1024 : int'(len)) : 0;
      pn = 9'((dd + 3) / 4);
      if (fmt[1] && typ[4:3] == 2'b00)                      return {3'b110, pn};
      if (!fmt[1] && typ != 5'b01010 && typ != 5'b01011)    return {3'b001, 9'd0};
      return 12'd0;
   endfunction

   // Scoreboard monitor: every FIFO write and credit pulse pops an expectation.
   always @(negedge clk_125) begin
      if (rstn) begin
         if (rx_fifo_wr) begin
            if (exp_wr_q.size() == 0) check("fifo_wr_unexpected", 66'd1, 66'd0);
            else check("fifo_data", rx_fifo_data, exp_wr_q.pop_front());
         end
         if (ph_cr || pd_cr || nph_cr) begin
            if (exp_cr_q.size() == 0) check("credit_unexpected", {ph_cr, pd_cr, nph_cr, pd_num}, 66'd0);
            else check("credit", {ph_cr, pd_cr, nph_cr, pd_num}, exp_cr_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_125); #1;
         rx_st = 1'b0; rx_end = 1'b0; rx_fifo_full = 1'b0;
      end
   endtask

   task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                           input int nbeats, input int full_from, input int full_n, input bit abandon);
      logic [63:0] d;
      logic [11:0] cr;
      bit st, en, fl;
      for (int b = 0; b < nbeats; b++) begin
         d = {$urandom, $urandom};
         if (b == 0) begin
            d[62:61] = fmt; d[60:56] = typ; d[41:32] = len;
         end
         st = (b == 0);
         en = !abandon && (b == nbeats - 1);
         fl = (b >= full_from) && (b < full_from + full_n);
         @(posedge clk_125); #1;
         rx_st = st; rx_end = en; rx_data = d; rx_fifo_full = fl;
         if (fl) m_eo = 1;
         else exp_wr_q.push_back({st, en, d});
      end
      if (!abandon) begin
         m_cnt++;
         if (nbeats != exp_beats(fmt, len)) m_el = 1;
         cr = exp_credit(fmt, typ, len);
         if (cr != 12'd0) exp_cr_q.push_back(cr);
      end
   endtask

   task automatic run_pulse();
      @(posedge clk_125); #1;
      run = 1'b0; rx_st = 1'b0; rx_end = 1'b0; rx_fifo_full = 1'b0;
      @(posedge clk_125); #1;
      run = 1'b1;
      idle(3);
      m_cnt = 0; m_ef = 0; m_el = 0; m_eo = 0;
   endtask

   task automatic check_status(input string tag);
      idle(3);
      check({tag, "_tlp_cnt"}, tlp_cnt, m_cnt);
      check({tag, "_err_frame"}, err_frame, m_ef);
      check({tag, "_err_len"}, err_len, m_el);
      check({tag, "_err_ovf"}, err_ovf, m_eo);
   endtask

   initial begin
      logic [1:0] fmt;
      logic [4:0] typ;
      logic [9:0] len;
      int nb, ff, fn;

      #13;
      check("rst_strobes", {rx_fifo_wr, ph_cr, pd_cr, nph_cr, done}, 66'd0);
      check("rst_sm", sm, 66'd0);
      check("rst_pd_num", pd_num, 66'd0);
      check("rst_cnt_err", {tlp_cnt, err_frame, err_len, err_ovf}, 66'd0);
      check("rst_fifo_data", rx_fifo_data, 66'd0);
      rstn = 1'b1; enable = 1'b1; run = 1'b1;
      idle(3);
      check("hdr_after_run", sm, 66'd1);

      // MWr 32-bit, 4 DW of data, 4 beats.
      send_tlp(2'b10, 5'b00000, 10'd4, 4, 0, 0, 0);
      check_status("mwr4");

      // Three back-to-back 64-bit MRd against a target of 3.
      run_pulse();
      rx_cycles = 16'd3;
      for (int i = 0; i < 3; i++) send_tlp(2'b01, 5'b00000, 10'($urandom), 2, 0, 0, 0);
      check_status("mrd3");
      check("mrd3_done", done, 66'd1);
      check("mrd3_sm", sm, 66'b110);
      run_pulse();
      check("done_cleared", {done, sm}, {1'b0, 3'b001});
      rx_cycles = 16'd0;

      // Maximum length write, then the same header one beat short.
      send_tlp(2'b10, 5'b00000, 10'd0, 514, 0, 0, 0);
      check_status("mwr1024");
      send_tlp(2'b10, 5'b00000, 10'd0, 513, 0, 0, 0);
      check_status("mwr1024_short");

      // FIFO full for two beats mid-TLP.
      run_pulse();
      send_tlp(2'b10, 5'b00000, 10'd8, 6, 2, 2, 0);
      check_status("ovf");

      // Restart mid-packet, then a lone rx_end in HDR.
      run_pulse();
      send_tlp(2'b10, 5'b00000, 10'd4, 2, 0, 0, 1);
      send_tlp(2'b10, 5'b00000, 10'd4, 4, 0, 0, 0);
      m_ef = 1;
      check_status("restart");
      run_pulse();
      check_status("run_clear");
      @(posedge clk_125); #1;
      rx_end = 1'b1;
      m_ef = 1;
      check_status("lone_end");

      // Randomized traffic mix.
      run_pulse();
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: begin fmt = 2'b10; typ = 5'b00000; end
            1: begin fmt = 2'b11; typ = 5'b00000; end
            2: begin fmt = 2'b00; typ = 5'b00000; end
            3: begin fmt = 2'b01; typ = 5'b00000; end
            4: begin fmt = 2'b10; typ = 5'b01010; end
            default: begin fmt = 2'b00; typ = 5'b01010; end
         endcase
         len = fmt[1] ? 10'($urandom_range(1, 16)) : 10'($urandom);
         nb = exp_beats(fmt, len);
         if ($urandom_range(0, 7) == 0) nb = ($urandom_range(0, 1) == 1 || nb == 1) ? nb + 1 : nb - 1;
         ff = 0; fn = 0;
         if ($urandom_range(0, 3) == 0) begin
            ff = $urandom_range(0, nb - 1);
            fn = $urandom_range(1, 2);
         end
         send_tlp(fmt, typ, len, nb, ff, fn, 0);
         idle($urandom_range(0, 2));
      end
      check_status("random");

      // Reset in the middle of a TLP.
      send_tlp(2'b10, 5'b00000, 10'd4, 2, 0, 0, 1);
      @(posedge clk_125);
      @(negedge clk_125); #1;
      rstn = 1'b0; rx_st = 1'b0; rx_end = 1'b0;
      #1;
      check("rstmid_strobes", {rx_fifo_wr, ph_cr, pd_cr, nph_cr, done}, 66'd0);
      check("rstmid_cnt_err", {tlp_cnt, err_frame, err_len, err_ovf}, 66'd0);
      check("rstmid_sm", sm, 66'd0);
      m_cnt = 0; m_ef = 0; m_el = 0; m_eo = 0;
      @(posedge clk_125); #1;
      rstn = 1'b1;
      idle(3);
      send_tlp(2'b10, 5'b00000, 10'd4, 4, 0, 0, 0);
      check_status("after_rst");

      idle(3);
      check("wr_queue_empty", 66'(exp_wr_q.size()), 66'd0);
      check("cr_queue_empty", 66'(exp_cr_q.size()), 66'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sfif_rx_ctrl.md
# sfif_rx_ctrl

Receive-side controller for the simple fabric interface (SFIF) PCIe test path. It sits between the PCIe core's 64-bit receive TLP stream and the RX capture FIFO. It parses each TLP header, checks framing and length, writes accepted beats into the FIFO, and returns posted and non-posted credits to the core. It counts received TLPs against a programmed target, so it can act as the far end of the SFIF transmit controller's packet bursts.

## Interface
Parameters:
- none (widths fixed: 64-bit data, 16-bit counters).

Ports:
- clk_125  in  1  core clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- enable  in  1  block enable; 0 holds sm in IDLE, stream ignored
- run  in  1  rising edge (registered compare) clears tlp_cnt, errors, done
- rx_cycles  in  16  target TLP count; 0 = never done
- loop  in  1  1 = ignore target, never enter DONE
- rx_st  in  1  first beat of TLP (header DW0/DW1 on rx_data)
- rx_end  in  1  last beat of TLP
- rx_data  in  64  beat data; DW0 in [63:32]
- rx_fifo_full  in  1  capture FIFO full
- rx_fifo_wr  out  1  FIFO write strobe
- rx_fifo_data  out  66  {rx_st, rx_end, rx_data} registered
- ph_cr, pd_cr, nph_cr  out  1  one-cycle credit-return pulses
- pd_num  out  9  posted data credits returned with pd_cr
- tlp_cnt  out  16  TLPs completed since clear
- err_frame, err_len, err_ovf  out  1  sticky errors
- done  out  1  sm==DONE
- sm  out  3  state, for debug

## Operation
- States: IDLE=000, HDR=001, DATA=010, CREDIT=011, DONE=110. Other encodings go to IDLE.
- IDLE→HDR when enable=1 and run=1.
- HDR: wait for rx_st. On rx_st, latch the header fields:
  - fmt=rx_data[62:61], type=rx_data[60:56], len=rx_data[41:32].
  - hdr_dw=fmt[0]?4:3.
  - data_dw=fmt[1]?(len==0?1024:len):0.
  - exp_beats=ceil((hdr_dw+data_dw)/2), 10-bit.
  - Beat counter=1.
  - If rx_end on the same beat, go to CREDIT; else go to DATA.
- rx_end without rx_st in HDR: err_frame=1, no state change.
- DATA: each cycle with beat activity, increment the beat counter; on rx_end go to CREDIT.
  - rx_end is the only activity marker.
  - Every cycle in DATA is a beat: the core's stream is back-to-back.
- rx_st seen in DATA: err_frame=1, abandon the current TLP (no credit), and restart header capture with this beat.
- Length check at rx_end: if beat count ≠ exp_beats, err_len=1. The TLP still counts and credits are still returned.
- CREDIT (one cycle), classified on the latched type:
  - Posted (type[4:3]=00, fmt[1]=1): ph_cr=1, pd_cr=1, pd_num=ceil(data_dw/4) (1024 DW → 256).
  - Non-posted (fmt[1]=0, type≠01010): nph_cr=1.
  - Completions (type=01010/01011): no credit pulse.
  - tlp_cnt increments, saturating at FFFF.
  - Next state is DONE if loop=0, rx_cycles≠0 and the new tlp_cnt==rx_cycles; else HDR.
- DONE: hold until the run rising edge (→IDLE, counters cleared) or reset.
- FIFO writes: every beat in HDR-with-rx_st and in DATA writes the FIFO if rx_fifo_full=0.
  - If full, the beat is dropped and err_ovf=1. Parsing continues.
  - The FIFO never sees a partial write after full deasserts mid-TLP; the remaining beats still write.
- enable=0 mid-TLP: go to IDLE next cycle with no credit or count. The next TLP starts clean.

## Timing
- Reset values: all outputs 0, sm=IDLE, pd_num=0.
- rx_fifo_wr/rx_fifo_data: one cycle after the input beat.
- Credit pulses: exactly one cycle wide, in the cycle after the rx_end beat (the CREDIT state).
- A TLP starting in the cycle immediately after rx_end (back-to-back) lands while sm=CREDIT. It is accepted: CREDIT treats rx_st exactly as HDR does and goes to DATA/CREDIT directly, so no beat is lost.
- tlp_cnt updates in the CREDIT cycle and is visible the next cycle. done asserts the cycle after the CREDIT that hits the target.
- err_* are sticky until reset or the run rising edge. The run edge has priority over a simultaneous error set.
- Reset asserted mid-TLP: all state clears immediately (asynchronous). No credits are emitted for the partial TLP.

## Test plan
- MWr 32-bit, len=4 (3+4 DW → 4 beats): rx_st..rx_end over 4 cycles → 4 FIFO writes, then ph_cr=pd_cr=1 with pd_num=1 one cycle after rx_end, tlp_cnt=1, no errors.
- MRd 64-bit (fmt=01, 4 DW, 2 beats), rx_cycles=3, loop=0, three back-to-back TLPs with no idle gap → three nph_cr pulses, tlp_cnt=3, done=1, sm=110.
- MWr len=0 (1024 DW, 514 beats) → pd_num=256, err_len=0. The same header sent with 513 beats → err_len=1, credits still returned.
- rx_fifo_full held for 2 beats mid-TLP → those 2 beats not written, err_ovf=1, remaining beats written, tlp_cnt increments.
- rx_st asserted mid-packet → err_frame=1, first TLP gets no credit, second TLP is credited normally. A lone rx_end in HDR → err_frame=1.
- rstn pulsed mid-TLP → all outputs 0 immediately, no credit pulse. The next complete TLP is processed normally; the run edge clears the sticky errors.
